i2s_tx_sequencer: RTL and testbench
===================================

# i2s_tx_sequencer

Sequences the synthesiser's audio DAC output. Generates the free-running DAC master clock, the serial bit clock, and the left/right word clock from the system clock. Accepts stereo sample pairs from the synthesis engine over a valid/ready handshake and shifts them out MSB-first in Philips I2S format, with one sample of buffering and underrun detection. Sits between the synth voice mixer and the DAC pins (mclk, lrck, sck, sdout).

## Interface
- WIDTH, 16: sample width in bits per channel; legal range 1..31.
- MCLK_HALF, 1: clk cycles per mclk half-period.
- SCK_HALF, 4: clk cycles per sck half-period; must be ≥ 2.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request; sampled only at frame boundaries and in IDLE.
- sample_l  in  WIDTH  left sample, two's complement.
- sample_r  in  WIDTH  right sample, two's complement.
- sample_valid  in  1  sample pair valid.
- sample_ready  out  1  holding register empty; transfer when valid && ready.
- mclk  out  1  DAC master clock.
- sck  out  1  serial bit clock.
- lrck  out  1  word clock: 0 = left, 1 = right.
- sdout  out  1  serial data.
- underrun  out  1  one-clk pulse when a frame starts with no buffered sample.
- underrun_cnt  out  8  saturating underrun count.

## Operation
- Reset values: mclk 0, sck 0, lrck 0, sdout 0, sample_ready 1, underrun 0, underrun_cnt 0. All counters are 0. State is IDLE. The holding register is empty.
- mclk toggles every MCLK_HALF clk from reset, independent of en and state.
- States:
  - IDLE: sck, lrck and sdout are held at 0.
  - IDLE → RUN on the first clk with en = 1.
  - RUN → IDLE only at a frame boundary with en = 0.
- Holding register:
  - Accepts when sample_valid && sample_ready. Accepts in both states.
  - sample_ready = !full.
- In RUN, div_cnt counts 0 .. 2*SCK_HALF-1 and wraps.
- Fall event: occurs when div_cnt wraps, and on the IDLE→RUN cycle.
  - sck ← 0.
  - bit_cnt advances 0..63 and wraps. On IDLE→RUN entry, bit_cnt ← 0.
  - lrck ← (new bit_cnt ≥ 32).
  - sdout ← slot bit for the new bit_cnt.
- Rise event: sck ← 1 when div_cnt = SCK_HALF-1. Data is stable across the sck rising edge.
- Frame: 64 sck periods. Left slot is bits 0..31, right slot is bits 32..63.
- I2S one-bit delay: left MSB at bit 1, left LSB at bit WIDTH. Right MSB at bit 33, right LSB at bit 32+WIDTH. All other bits output 0.
- Frame boundary is the fall event with new bit_cnt = 0.
  - If the holding register is full: copy it into the left/right shift registers and mark it empty. sample_ready rises the next clk.
  - If the holding register is empty: load zeros into both shift registers, pulse underrun, and increment underrun_cnt (saturates at 255).
  - If en = 0 at the boundary: go to IDLE instead of loading. The holding register is kept.
- A transfer accepted on the same clk as a boundary with an empty holding register is not bypassed. That frame is an underrun; the sample plays next frame.

## Timing
- sck period = 2*SCK_HALF clk. Frame = 128*SCK_HALF clk; 512 clk at defaults.
- sck, lrck and sdout change together, on the clk edge of the fall event.
- Latency, defaults, sample buffered before en rises:
  - lrck falls and bit 0 is on the IDLE→RUN cycle (T).
  - Left MSB on sdout at T+8.
  - Right MSB at T+264.
- Holding register refill window: one full frame minus 1 clk.
- en dropping mid-frame has no effect until the next boundary. The current frame always completes.
- Async reset mid-frame: outputs return to reset values immediately, and the buffered sample is discarded.

## Test plan
- Reset: hold rst = 0 with clk running, then release. Required: sck/lrck/sdout = 0, sample_ready = 1, mclk toggles every clk at MCLK_HALF = 1, underrun_cnt = 0.
- Single frame: preload L = 16'h8001, R = 16'h1234, then en = 1 at T.
  - sdout bits 1..16 = 1000_0000_0000_0001; bit 0 and bits 17..31 are 0.
  - bits 33..48 = 0001_0010_0011_0100.
  - lrck rises at T+256; sample_ready rises at T+1.
- Streaming: supply a new pair every frame for 4 frames from a counting pattern. Required: every pair appears in order, underrun never pulses, and each sample_ready rises 1 clk after its boundary.
- Underrun: run with no valid for 3 frames. Required: all-zero sdout, 3 single-clk underrun pulses at the boundaries, underrun_cnt = 3. Also run 300 frames: underrun_cnt saturates at 255.
- Stop/start: drop en at bit 10 of a frame. Required: the frame finishes through bit 63, then IDLE with all outputs 0. The buffered pair is retained and plays first after en returns.
- Race and reset: assert valid on the exact boundary clk with the holding register empty. Required: underrun pulses, and the pair plays in the following frame. Also assert rst mid-frame: outputs are 0 on the same edge, and sample_ready = 1.

Source files
------------

// File: rtl/i2s_tx_sequencer_if.sv
// Sample-pair handshake between the synth voice mixer (master) and the
// I2S transmit sequencer (slave).
//   sample_l / sample_r : left/right sample, two's complement, WIDTH bits
//   sample_valid        : master has a pair on sample_l/sample_r
//   sample_ready        : slave holding register can take a pair
// A pair transfers on a clk edge where sample_valid && sample_ready.
interface i2s_tx_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx_sequencer.sv
// Philips I2S transmitter for the synth DAC. Generates the free-running master
// clock, the bit clock and the word clock from clk, buffers one stereo pair
// and shifts each frame out MSB-first with the I2S one-bit delay.
//   clk          : system clock, everything on posedge
//   rst          : asynchronous active-low reset
//   en           : run request, honoured in IDLE and at frame boundaries
//   smp          : sample handshake (slave side of i2s_tx_sequencer_if)
//   mclk         : DAC master clock, toggles every MCLK_HALF clk
//   sck          : serial bit clock, period 2*SCK_HALF clk
//   lrck         : word clock, 0 = left slot, 1 = right slot
//   sdout        : serial data, changes with the falling edge of sck
//   underrun     : one-clk pulse when a frame starts with nothing buffered
//   underrun_cnt : saturating count of underrun pulses
module i2s_tx_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MCLK_HALF = 1,
  parameter int SCK_HALF  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  i2s_tx_sequencer_if.slave   smp,
  output logic                mclk,
  output logic                sck,
  output logic                lrck,
  output logic                sdout,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int MCW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int DW  = $clog2(2 * SCK_HALF);
  localparam logic [MCW-1:0] MC_LAST  = MCW'(MCLK_HALF - 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(2 * SCK_HALF - 1);
  localparam logic [DW-1:0]  RISE_AT  = DW'(SCK_HALF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [MCW-1:0]   mclk_cnt_r;
  logic [DW-1:0]    div_cnt_r;
  logic [5:0]       bit_cnt_r;
  logic [WIDTH-1:0] hold_l_r;
  logic [WIDTH-1:0] hold_r_r;
  logic [WIDTH-1:0] frame_l_r;
  logic [WIDTH-1:0] frame_r_r;
  logic             full_r;
  logic             ready_r;

  logic             wrap_s;
  logic             entry_s;
  logic [5:0]       next_bit_s;
  logic             boundary_s;
  logic             frame_start_s;
  logic             stop_s;
  logic             accept_s;
  logic             load_s;

  // Serial bit for frame position b: within each 32-bit slot, position p
  // (1..WIDTH) carries sample bit WIDTH-p; position 0 and the tail are zero.
  function automatic logic slot_bit(input logic [5:0]       b,
                                    input logic [WIDTH-1:0] l,
                                    input logic [WIDTH-1:0] r);
    logic [4:0]       p;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shifted;
    p = b[4:0];
    if (b[5]) begin
      word = r;
    end else begin
      word = l;
    end
    shifted = word >> (5'(WIDTH) - p);
    if ((p != 5'd0) && (p <= 5'(WIDTH))) begin
      return shifted[0];
    end else begin
      return 1'b0;
    end
  endfunction

  assign wrap_s        = (state_r == RUN) && (div_cnt_r == DIV_LAST);
  assign entry_s       = (state_r == IDLE) && en;
  assign next_bit_s    = bit_cnt_r + 6'd1;
  assign boundary_s    = wrap_s && (next_bit_s == 6'd0);
  assign frame_start_s = entry_s || (boundary_s && en);
  assign stop_s        = boundary_s && !en;
  // ready_r is only ever high while the holding register is empty, so an
  // accept and a boundary load can never coincide.
  assign accept_s      = smp.sample_valid && ready_r;
  assign load_s        = frame_start_s && full_r;

  assign smp.sample_ready = ready_r;

  // Free-running master clock divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mclk_cnt_r <= MCW'(0);
      mclk       <= 1'b0;
    end else if (mclk_cnt_r == MC_LAST) begin
      mclk_cnt_r <= MCW'(0);
      mclk       <= ~mclk;
    end else begin
      mclk_cnt_r <= mclk_cnt_r + MCW'(1);
      mclk       <= mclk;
    end
  end

  // Frame sequencer: state, bit-clock divider, bit counter and serial pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      div_cnt_r <= DW'(0);
      bit_cnt_r <= 6'd0;
      sck       <= 1'b0;
      lrck      <= 1'b0;
      sdout     <= 1'b0;
      frame_l_r <= WIDTH'(0);
      frame_r_r <= WIDTH'(0);
    end else begin
      case (state_r)
        IDLE: begin
          // Entry is itself a fall event at bit 0, so all pins stay low.
          state_r   <= entry_s ? RUN : IDLE;
          div_cnt_r <= DW'(0);
          bit_cnt_r <= 6'd0;
          sck       <= 1'b0;
          lrck      <= 1'b0;
          sdout     <= 1'b0;
        end
        RUN: begin
          if (wrap_s) begin
            // Fall event; bit 0 of a new frame always drives lrck/sdout low,
            // which also leaves the pins at their idle value on a stop.
            state_r   <= stop_s ? IDLE : RUN;
            div_cnt_r <= DW'(0);
            bit_cnt_r <= next_bit_s;
            sck       <= 1'b0;
            lrck      <= next_bit_s[5];
            sdout     <= slot_bit(next_bit_s, frame_l_r, frame_r_r);
          end else begin
            state_r   <= RUN;
            div_cnt_r <= div_cnt_r + DW'(1);
            bit_cnt_r <= bit_cnt_r;
            sck       <= (div_cnt_r == RISE_AT) ? 1'b1 : sck;
            lrck      <= lrck;
            sdout     <= sdout;
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= DW'(0);
          bit_cnt_r <= 6'd0;
          sck       <= 1'b0;
          lrck      <= 1'b0;
          sdout     <= 1'b0;
        end
      endcase
      if (frame_start_s) begin
        frame_l_r <= full_r ? hold_l_r : WIDTH'(0);
        frame_r_r <= full_r ? hold_r_r : WIDTH'(0);
      end else begin
        frame_l_r <= frame_l_r;
        frame_r_r <= frame_r_r;
      end
    end
  end

  // Holding register, ready flag and underrun reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_l_r     <= WIDTH'(0);
      hold_r_r     <= WIDTH'(0);
      full_r       <= 1'b0;
      ready_r      <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      if (accept_s) begin
        hold_l_r <= smp.sample_l;
        hold_r_r <= smp.sample_r;
        full_r   <= 1'b1;
        ready_r  <= 1'b0;
      end else if (load_s) begin
        // Ready reopens one clk after the boundary that drained the register.
        full_r   <= 1'b0;
        ready_r  <= 1'b0;
      end else begin
        full_r   <= full_r;
        ready_r  <= !full_r;
      end
      underrun <= frame_start_s && !full_r;
      if (frame_start_s && !full_r && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end else begin
        underrun_cnt <= underrun_cnt;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
module tb_i2s_tx_sequencer;
  localparam int W     = 16;
  localparam int SH    = 4;
  localparam int MH    = 1;
  localparam int FRAME = 128 * SH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic mclk, sck, lrck, sdout, underrun;
  logic [7:0] underrun_cnt;

  logic rst2 = 1'b0;
  logic en2  = 1'b0;
  logic mclk2, sck2, lrck2, sdout2, und2;
  logic [7:0] cnt2;
  logic done2 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx_sequencer_if #(.WIDTH(W)) smp_if ();
  i2s_tx_sequencer_if #(.WIDTH(W)) smp2_if ();

  i2s_tx_sequencer #(.WIDTH(W), .MCLK_HALF(MH), .SCK_HALF(SH)) dut (
    .clk(clk), .rst(rst), .en(en), .smp(smp_if),
    .mclk(mclk), .sck(sck), .lrck(lrck), .sdout(sdout),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  // Second instance: shortest legal frame, used only to reach saturation.
  i2s_tx_sequencer #(.WIDTH(W), .MCLK_HALF(2), .SCK_HALF(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .smp(smp2_if),
    .mclk(mclk2), .sck(sck2), .lrck(lrck2), .sdout(sdout2),
    .underrun(und2), .underrun_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame/time arithmetic) ----------------
  bit          m_run, m_full, m_loaded, m_und;
  int          m_k, m_cnt, m_n;
  logic [15:0] m_hl, m_hr, m_pl, m_pr;

  always @(posedge clk) begin
    bit          ready_before, start;
    int          b, ph;
    logic [63:0] fv;
    #1;
    if (!rst) begin
      m_run = 0; m_full = 0; m_loaded = 0; m_und = 0;
      m_k = 0; m_cnt = 0; m_n = 0;
      m_hl = '0; m_hr = '0; m_pl = '0; m_pr = '0;
    end else begin
      m_n++;
      ready_before = !m_full && !m_loaded;
      m_loaded = 0;
      m_und = 0;
      start = 0;
      if (m_run) begin
        m_k++;
        if (m_k == FRAME) begin
          m_k = 0;
          if (en) start = 1;
          else m_run = 0;
        end
      end else if (en) begin
        m_run = 1;
        m_k = 0;
        start = 1;
      end
      if (start) begin
        if (m_full) begin
          m_pl = m_hl; m_pr = m_hr; m_full = 0; m_loaded = 1;
        end else begin
          m_pl = '0; m_pr = '0; m_und = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (smp_if.sample_valid && ready_before) begin
        m_hl = smp_if.sample_l; m_hr = smp_if.sample_r; m_full = 1;
      end
    end
    b  = m_k / (2 * SH);
    ph = m_k % (2 * SH);
    fv = {1'b0, m_pl, 15'd0, 1'b0, m_pr, 15'd0};
    chk("m_mclk", mclk, 32'((m_n / MH) % 2));
    chk("m_sck", sck, 32'(m_run && (ph >= SH)));
    chk("m_lrck", lrck, 32'(m_run && (b >= 32)));
    chk("m_sdout", sdout, 32'(m_run ? fv[63 - b] : 1'b0));
    chk("m_ready", smp_if.sample_ready, 32'(!m_full && !m_loaded));
    chk("m_underrun", underrun, 32'(m_und));
    chk("m_underrun_cnt", underrun_cnt, 32'(m_cnt));
  end

  // ---------------- helpers ----------------
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit ok;
    ok = 0;
    @(negedge clk);
    smp_if.sample_l = l; smp_if.sample_r = r; smp_if.sample_valid = 1'b1;
    for (int w = 0; w < 1200 && !ok; w++) begin
      if (smp_if.sample_ready) ok = 1;
      @(negedge clk);
    end
    smp_if.sample_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  // Called right after the k=0 sample of a frame; returns at the k=FRAME-1 sample.
  task automatic capture_frame(output logic [15:0] l, output logic [15:0] r, output int extra);
    int b;
    l = '0; r = '0; extra = 0;
    for (int k = 1; k < FRAME; k++) begin
      @(posedge clk); #1;
      if (k % (2 * SH) == SH) begin
        b = k / (2 * SH);
        if (b >= 1 && b <= 16) l[16 - b] = sdout;
        else if (b >= 33 && b <= 48) r[48 - b] = sdout;
        else if (sdout) extra++;
      end
    end
  endtask

  // ---------------- saturation run on the second instance ----------------
  initial begin
    int p;
    p = 0;
    smp2_if.sample_valid = 1'b0;
    smp2_if.sample_l = '0;
    smp2_if.sample_r = '0;
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    en2  = 1'b1;
    for (int e = 0; e < 70000 && p < 258; e++) begin
      @(posedge clk); #1;
      if (und2) begin
        p++;
        chk("sat_cnt_step", cnt2, (p > 255) ? 255 : p);
      end
    end
    chk("sat_pulses", p, 258);
    chk("sat_final", cnt2, 8'd255);
    done2 = 1'b1;
  end

  // ---------------- directed main sequence ----------------
  initial begin
    logic [15:0] wl, wr;
    int          extra, pulses, b;
    logic        m1;

    smp_if.sample_valid = 1'b0;
    smp_if.sample_l = '0;
    smp_if.sample_r = '0;

    // Reset
    repeat (4) @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_sdout", sdout, 0);
    chk("rst_ready", smp_if.sample_ready, 1);
    chk("rst_cnt", underrun_cnt, 0);
    chk("rst_mclk", mclk, 0);
    rst = 1'b1;
    @(posedge clk); #1; m1 = mclk;
    @(posedge clk); #1;
    chk("mclk_toggle", mclk, !m1);

    // Single frame
    send(16'h8001, 16'h1234);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    chk("sf_ready_T", smp_if.sample_ready, 0);
    chk("sf_lrck_T", lrck, 0);
    wl = '0; wr = '0; extra = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("sf_ready_T1", smp_if.sample_ready, 1);
      if (k == 8) chk("sf_msb_T8", sdout, 1);
      if (k == 255) chk("sf_lrck_255", lrck, 0);
      if (k == 256) chk("sf_lrck_256", lrck, 1);
      if (k % (2 * SH) == SH) begin
        b = k / (2 * SH);
        if (b >= 1 && b <= 16) wl[16 - b] = sdout;
        else if (b >= 33 && b <= 48) wr[48 - b] = sdout;
        else if (sdout) extra++;
      end
    end
    chk("sf_left", wl, 16'h8001);
    chk("sf_right", wr, 16'h1234);
    chk("sf_zero_bits", extra, 0);

    // Streaming: four pairs, one per frame
    for (int i = 0; i < 4; i++) begin
      send(16'h0101 * 16'(i + 1), ~(16'h0101 * 16'(i + 1)));
    end

    // Underrun: nothing more supplied, expect three pulses
    pulses = 0;
    for (int e = 0; e < 3000 && pulses < 3; e++) begin
      @(posedge clk); #1;
      if (underrun) pulses++;
    end
    chk("ur_pulses", pulses, 3);
    chk("ur_cnt", underrun_cnt, 8'd3);

    // Stop/start: drop en at bit 10, buffer a pair, frame must finish
    repeat (80) @(posedge clk);
    @(negedge clk); en = 1'b0;
    send(16'hA5C3, 16'h3C5A);
    repeat (600) @(posedge clk);
    #1;
    chk("stop_sck", sck, 0);
    chk("stop_lrck", lrck, 0);
    chk("stop_sdout", sdout, 0);
    chk("stop_ready_held", smp_if.sample_ready, 0);
    chk("stop_cnt", underrun_cnt, 8'd3);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    chk("restart_underrun", underrun, 0);
    capture_frame(wl, wr, extra);
    chk("restart_left", wl, 16'hA5C3);
    chk("restart_right", wr, 16'h3C5A);

    // Race: valid lands on the boundary clk with the register empty
    @(negedge clk);
    smp_if.sample_l = 16'h7FFE; smp_if.sample_r = 16'h0F0F; smp_if.sample_valid = 1'b1;
    @(posedge clk); #1;
    chk("race_underrun", underrun, 1);
    chk("race_ready", smp_if.sample_ready, 0);
    @(negedge clk); smp_if.sample_valid = 1'b0;
    capture_frame(wl, wr, extra);
    chk("race_zero_frame", {wl, wr}, 32'h0);
    @(posedge clk); #1;
    chk("race_next_no_underrun", underrun, 0);
    capture_frame(wl, wr, extra);
    chk("race_left", wl, 16'h7FFE);
    chk("race_right", wr, 16'h0F0F);

    // Async reset mid-frame with a pair buffered
    @(negedge clk);
    smp_if.sample_l = 16'h1111; smp_if.sample_r = 16'h2222; smp_if.sample_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); smp_if.sample_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("pre_rst_lrck", lrck, 1);
    chk("pre_rst_ready", smp_if.sample_ready, 0);
    chk("pre_rst_cnt", underrun_cnt, 8'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_sck", sck, 0);
    chk("arst_lrck", lrck, 0);
    chk("arst_sdout", sdout, 0);
    chk("arst_ready", smp_if.sample_ready, 1);
    chk("arst_cnt", underrun_cnt, 0);
    chk("arst_mclk", mclk, 0);
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_ready", smp_if.sample_ready, 1);
    chk("post_rst_lrck", lrck, 0);

    for (int w = 0; w < 80000 && !done2; w++) @(posedge clk);
    chk("sat_done", done2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
